// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: fixed-latency multiply, radix-2 restoring divide,
// architectural divide corner cases resolved at issue without iterating.
module muldiv_sequencer #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [2:0]             op_r;
    logic [XLEN-1:0]        a_r;      // multiplicand, or dividend magnitude shifting into quotient
    logic [XLEN-1:0]        b_r;      // multiplier, or divisor magnitude
    logic [XLEN-1:0]        rem_r;
    logic                   q_neg_r;
    logic                   r_neg_r;
    logic [XLEN-1:0]        result_r;
    logic                   done_r;

    logic                   accept_s;
    logic [CNT_W-1:0]       cnt_dec_s;
    logic [2:0]             mop_s;
    logic [XLEN-1:0]        ma_s;
    logic [XLEN-1:0]        mb_s;
    logic signed [XLEN:0]   a_ext_s;
    logic signed [XLEN:0]   b_ext_s;
    logic signed [2*XLEN+1:0] prod_s;
    logic [XLEN-1:0]        mul_res_s;
    logic [XLEN:0]          partial_s;
    logic [XLEN:0]          diff_s;
    logic [XLEN-1:0]        rem_nx_s;
    logic [XLEN-1:0]        quo_nx_s;
    logic [XLEN-1:0]        fix_res_s;
    logic                   sdiv_s;
    logic                   rs1_neg_s;
    logic                   rs2_neg_s;
    logic [XLEN-1:0]        rs1_mag_s;
    logic [XLEN-1:0]        rs2_mag_s;

    // Datapath: product, one restoring step, sign fix-up and issue-time operand prep.
    always_comb begin
        accept_s  = (state_r == S_IDLE) && start && !flush;
        cnt_dec_s = cnt_r - CNT_W'(1);

        // In IDLE the multiplier sees the live inputs so a single-cycle latency still works.
        mop_s   = (state_r == S_IDLE) ? op  : op_r;
        ma_s    = (state_r == S_IDLE) ? rs1 : a_r;
        mb_s    = (state_r == S_IDLE) ? rs2 : b_r;
        a_ext_s = {((mop_s == 3'd1) || (mop_s == 3'd2)) & ma_s[XLEN-1], ma_s};
        b_ext_s = {(mop_s == 3'd1) & mb_s[XLEN-1], mb_s};
        prod_s  = $signed({{(XLEN+1){a_ext_s[XLEN]}}, a_ext_s})
                * $signed({{(XLEN+1){b_ext_s[XLEN]}}, b_ext_s});
        if (mop_s == 3'd0) begin
            mul_res_s = prod_s[XLEN-1:0];
        end else begin
            mul_res_s = prod_s[2*XLEN-1:XLEN];
        end

        partial_s = {rem_r, a_r[XLEN-1]};
        diff_s    = partial_s - {1'b0, b_r};
        if (!diff_s[XLEN]) begin
            rem_nx_s = diff_s[XLEN-1:0];
            quo_nx_s = {a_r[XLEN-2:0], 1'b1};
        end else begin
            rem_nx_s = partial_s[XLEN-1:0];
            quo_nx_s = {a_r[XLEN-2:0], 1'b0};
        end

        if (op_r[1]) begin
            fix_res_s = r_neg_r ? (~rem_r + XLEN'(1)) : rem_r;
        end else begin
            fix_res_s = q_neg_r ? (~a_r + XLEN'(1)) : a_r;
        end

        sdiv_s    = op[2] & ~op[0];
        rs1_neg_s = sdiv_s & rs1[XLEN-1];
        rs2_neg_s = sdiv_s & rs2[XLEN-1];
        rs1_mag_s = rs1_neg_s ? (~rs1 + XLEN'(1)) : rs1;
        rs2_mag_s = rs2_neg_s ? (~rs2 + XLEN'(1)) : rs2;
    end

    // Sequencer FSM with registered result and done pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            op_r     <= 3'd0;
            a_r      <= '0;
            b_r      <= '0;
            rem_r    <= '0;
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            result_r <= '0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        op_r <= op;
                        if (!op[2]) begin
                            a_r <= rs1;
                            b_r <= rs2;
                            if (MUL_LATENCY == 1) begin
                                state_r  <= S_DONE;
                                result_r <= mul_res_s;
                                done_r   <= 1'b1;
                            end else begin
                                state_r <= S_MUL;
                                cnt_r   <= CNT_W'(MUL_LATENCY - 1);
                            end
                        end else if (rs2 == '0) begin
                            state_r  <= S_DONE;
                            result_r <= op[1] ? rs1 : '1;
                            done_r   <= 1'b1;
                        end else if (sdiv_s && (rs1 == INT_MIN) && (rs2 == '1)) begin
                            state_r  <= S_DONE;
                            result_r <= op[1] ? '0 : INT_MIN;
                            done_r   <= 1'b1;
                        end else begin
                            state_r <= S_DIV;
                            a_r     <= rs1_mag_s;
                            b_r     <= rs2_mag_s;
                            rem_r   <= '0;
                            q_neg_r <= rs1_neg_s ^ rs2_neg_s;
                            r_neg_r <= rs1_neg_s;
                            cnt_r   <= CNT_W'(XLEN);
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state_r <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_dec_s;
                        if (cnt_dec_s == '0) begin
                            state_r  <= S_DONE;
                            result_r <= mul_res_s;
                            done_r   <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state_r <= S_IDLE;
                    end else begin
                        rem_r <= rem_nx_s;
                        a_r   <= quo_nx_s;
                        cnt_r <= cnt_dec_s;
                        if (cnt_dec_s == '0) begin
                            state_r <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r  <= S_DONE;
                        result_r <= fix_res_s;
                        done_r   <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Upstream hold: the accept cycle plus every working state, never while in reset.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            stall = 1'b0;
        end else begin
            stall = accept_s || (state_r == S_MUL) || (state_r == S_DIV) || (state_r == S_FIX);
        end
    end

    assign done   = done_r;
    assign result = result_r;
    assign busy   = (state_r != S_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus randomized ops
// against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        busy;

    int unsigned passed;
    int unsigned total;

    muldiv_sequencer #(.XLEN(32), .MUL_LATENCY(2)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] pv;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin pv = 64'(sa * sb); return pv[31:0];  end
            3'd1: begin pv = 64'(sa * sb); return pv[63:32]; end
            3'd2: begin pv = 64'(sa * ub); return pv[63:32]; end
            3'd3: begin pv = 64'(ua * ub); return pv[63:32]; end
            3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o < 3'd4) return 2;
        if (b == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one op from IDLE and wait for done; returns in the done cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output bit acc_stall, output bit stall_ok);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        #1;
        acc_stall = (stall === 1'b1);
        tick();
        start = 1'b0;
        lat = 1;
        stall_ok = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
            tick();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        if (stall !== 1'b0) stall_ok = 1'b0;
        res = result;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd6; flush = 1'b0;
        tick(); tick();
        total++;
        if ({done, busy, stall} !== 3'b000 || result !== 32'd0) begin
            $display("FAIL reset_state: done=%b busy=%b stall=%b result=%h expected 0 0 0 00000000", done, busy, stall, result);
        end else passed++;
        start = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] exs [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hC000_0000};
        int lat; logic [31:0] res; bit acc; bit sok;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], lat, res, acc, sok);
            total++;
            if (res !== exs[i] || lat !== 2) begin
                $display("FAIL mul_%0d: result=%h lat=%0d expected %h lat=2", i, res, lat, exs[i]);
            end else passed++;
            total++;
            if (!acc || !sok) begin
                $display("FAIL mul_stall_%0d: accept_stall=%b window_ok=%b expected 1 1", i, acc, sok);
            end else passed++;
            tick();
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [8] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [8] = '{32'd6, 32'd6, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exs [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};
        int          lts [8] = '{34, 34, 34, 34, 1, 1, 1, 1};
        int lat; logic [31:0] res; bit acc; bit sok;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i], lat, res, acc, sok);
            total++;
            if (res !== exs[i] || lat !== lts[i] || !acc || !sok) begin
                $display("FAIL div_%0d: result=%h lat=%0d stall_ok=%b expected %h lat=%0d stall_ok=1", i, res, lat, acc && sok, exs[i], lts[i]);
            end else passed++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [2:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] exp_r;
        int lat; logic [31:0] res; bit acc; bit sok; int sel;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            if (sel == 3) b = -32'($urandom_range(1, 15));
            exp_r = model_result(o, a, b);
            issue(o, a, b, lat, res, acc, sok);
            total++;
            if (res !== exp_r || lat !== model_latency(o, a, b) || !acc || !sok) begin
                $display("FAIL rand_%0d op=%0d a=%h b=%h: result=%h lat=%0d expected %h lat=%0d", i, o, a, b, res, lat, exp_r, model_latency(o, a, b));
            end else passed++;
            tick();
        end
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res; bit acc; bit sok; bit saw_done;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, acc, sok);
        tick();
        // flush coincident with start: not accepted
        op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL flush_with_start: busy=%b done=%b expected 0 0", busy, done);
        end else passed++;
        start = 1'b1;
        tick();
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (done === 1'b1) saw_done = 1'b1;
        total++;
        if (busy !== 1'b0 || saw_done || result !== 32'hFFFF_FFFE) begin
            $display("FAIL flush_abort: busy=%b done_seen=%b result=%h expected 0 0 fffffffe", busy, saw_done, result);
        end else passed++;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        total++;
        if (saw_done) begin
            $display("FAIL flush_no_done: done pulse seen=1 expected 0");
        end else passed++;
        issue(3'd5, 32'd1000, 32'd3, lat, res, acc, sok);
        total++;
        if (res !== 32'd333 || lat !== 34) begin
            $display("FAIL flush_restart: result=%0d lat=%0d expected 333 lat=34", res, lat);
        end else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; bit acc; bit sok; int n;
        issue(3'd4, 32'd77, 32'd5, lat, res, acc, sok);
        tick();
        op = 3'd4; rs1 = 32'hFFFF_0000; rs2 = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        total++;
        if ({done, busy, stall} !== 3'b000 || result !== 32'd0) begin
            $display("FAIL reset_mid_op: done=%b busy=%b stall=%b result=%h expected 0 0 0 00000000", done, busy, stall, result);
        end else passed++;
        reset = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_no_done: busy=%b done=%b expected 0 0", busy, done);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; bit acc; bit sok; int n;
        issue(3'd0, 32'd3, 32'd4, lat, res, acc, sok);
        op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0 || done !== 1'b1 || result !== 32'd12) begin
            $display("FAIL done_cycle: stall=%b done=%b result=%0d expected 0 1 12", stall, done, result);
        end else passed++;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b1) begin
            $display("FAIL start_in_done_ignored: busy=%b done=%b stall=%b expected 0 0 1", busy, done, stall);
        end else passed++;
        tick();
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (done !== 1'b1 || result !== 32'd14 || n !== 34) begin
            $display("FAIL back_to_back: done=%b result=%0d lat=%0d expected 1 14 lat=34", done, result, n);
        end else passed++;
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd14) begin
            $display("FAIL result_hold: done=%b busy=%b result=%0d expected 0 0 14", done, busy, result);
        end else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        #2;
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
